// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 frame source: FSM states, pattern codes
// and the RGB565 colour-bar palette.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_e;

  localparam logic [1:0] PAT_SOLID_RED   = 2'd0;
  localparam logic [1:0] PAT_COLOUR_BARS = 2'd1;
  localparam logic [1:0] PAT_PIXEL_INDEX = 2'd2;
  localparam logic [1:0] PAT_CHECKER     = 2'd3;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 pixel generator. Only bit 3 of column and line matters
// (checkerboard tile parity), so just those bits are brought in.
module ov7670_pattern_gen
  import ov7670_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic        column_b3_i,
  input  logic        line_b3_i,
  input  logic [2:0]  bar_i,
  input  logic [15:0] index_i,
  output logic [15:0] pixel_o
);

  logic [15:0] bar_colour;

  always_comb begin
    bar_colour = RGB_BLACK;
    case (bar_i)
      3'd0: bar_colour = RGB_WHITE;
      3'd1: bar_colour = RGB_YELLOW;
      3'd2: bar_colour = RGB_CYAN;
      3'd3: bar_colour = RGB_GREEN;
      3'd4: bar_colour = RGB_MAGENTA;
      3'd5: bar_colour = RGB_RED;
      3'd6: bar_colour = RGB_BLUE;
      3'd7: bar_colour = RGB_BLACK;
      default: bar_colour = RGB_BLACK;
    endcase
  end

  always_comb begin
    pixel_o = RGB_RED;
    case (mode_i)
      PAT_SOLID_RED:   pixel_o = RGB_RED;
      PAT_COLOUR_BARS: pixel_o = bar_colour;
      PAT_PIXEL_INDEX: pixel_o = index_i;
      PAT_CHECKER:     pixel_o = (column_b3_i ^ line_b3_i) ? RGB_WHITE : RGB_BLACK;
      default:         pixel_o = RGB_RED;
    endcase
  end

endmodule

// File: rtl/ov7670_frame_source.sv
// OV7670 camera emulator: vsync/href/px_data RGB565 byte stream with
// OV7670-style frame timing. Outputs are registered from next-state values.
module ov7670_frame_source
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIX       = 160,
  parameter int unsigned V_LINES     = 120,
  parameter int unsigned H_BLANK     = 16,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 17,
  parameter int unsigned VFP_LINES   = 10
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] px_data,
  output logic       frame_done,
  output state_e     dbg_state
);

  localparam int unsigned TL      = 2 * H_PIX + H_BLANK;
  localparam int unsigned VS_LEN  = VSYNC_LINES * TL;
  localparam int unsigned VBP_LEN = VBP_LINES * TL;
  localparam int unsigned VFP_LEN = VFP_LINES * TL;
  localparam int unsigned ACT_LEN = 2 * H_PIX;
  localparam int unsigned MAX_LEN = max_u(max_u(VS_LEN, VBP_LEN), max_u(VFP_LEN, TL));
  localparam int unsigned CNT_W   = max_u($clog2(MAX_LEN), 1);
  localparam int unsigned COL_W   = max_u($clog2(H_PIX + 1), 4);
  localparam int unsigned LINE_W  = max_u($clog2(V_LINES), 4);
  localparam int unsigned BAR_W   = H_PIX / 8;
  localparam int unsigned BC_W    = max_u($clog2(BAR_W), 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [2:0]          bar_q, bar_d;
  logic [BC_W-1:0]     bar_col_q, bar_col_d;
  logic [15:0]         idx_q, idx_d;
  logic [1:0]          mode_q, mode_d;
  logic                vsync_q, href_q, done_q;
  logic [7:0]          px_q;
  logic [15:0]         pixel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    line_d    = line_q;
    bar_d     = bar_q;
    bar_col_d = bar_col_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_VSYNC;
          cnt_d   = '0;
          mode_d  = pattern_sel;
        end
      end
      ST_VSYNC: begin
        if (cnt_q == CNT_W'(VS_LEN - 1)) begin
          state_d = ST_VBP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VBP: begin
        if (cnt_q == CNT_W'(VBP_LEN - 1)) begin
          state_d   = ST_ACTIVE;
          cnt_d     = '0;
          line_d    = '0;
          col_d     = '0;
          bar_d     = '0;
          bar_col_d = '0;
          idx_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        // Odd byte closes a pixel: advance column, bar and running index.
        if (cnt_q[0]) begin
          col_d = col_q + COL_W'(1);
          idx_d = idx_q + 16'd1;
          if (bar_col_q == BC_W'(BAR_W - 1)) begin
            bar_col_d = '0;
            bar_d     = bar_q + 3'd1;
          end else begin
            bar_col_d = bar_col_q + BC_W'(1);
          end
        end
        if (cnt_q == CNT_W'(ACT_LEN - 1)) begin
          state_d = ST_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (line_q == LINE_W'(V_LINES - 1)) begin
            state_d = ST_VFP;
          end else begin
            state_d   = ST_ACTIVE;
            line_d    = line_q + LINE_W'(1);
            col_d     = '0;
            bar_d     = '0;
            bar_col_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VFP: begin
        if (cnt_q == CNT_W'(VFP_LEN - 1)) begin
          cnt_d = '0;
          if (en) begin
            state_d = ST_VSYNC;
            mode_d  = pattern_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ov7670_pattern_gen u_pattern_gen (
    .mode_i      (mode_d),
    .column_b3_i (col_d[3]),
    .line_b3_i   (line_d[3]),
    .bar_i       (bar_d),
    .index_i     (idx_d),
    .pixel_o     (pixel)
  );

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      line_q    <= '0;
      bar_q     <= '0;
      bar_col_q <= '0;
      idx_q     <= '0;
      mode_q    <= PAT_SOLID_RED;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      done_q    <= 1'b0;
      px_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      line_q    <= line_d;
      bar_q     <= bar_d;
      bar_col_q <= bar_col_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      vsync_q   <= (state_d == ST_VSYNC);
      href_q    <= (state_d == ST_ACTIVE);
      done_q    <= (state_d == ST_VFP) && (cnt_d == CNT_W'(VFP_LEN - 1));
      // Even byte in the line carries the high half of the pixel.
      px_q      <= (state_d == ST_ACTIVE) ? (cnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign px_data    = px_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
